// File: rtl/alu_pipe_n.sv
// ---------------------------------------------------------------------------
// alu_pipe_n
//   Two-stage pipelined WIDTH-bit ALU with valid/ready handshakes on both
//   sides. Stage 1 captures operands and opcode. Stage 2 computes the result
//   and the C/N/Z/V flags and holds them until the sink takes them. The block
//   sustains one operation per clock and stalls without losing data under
//   backpressure.
//
//   Optional feature: define ALU_PIPE_SAT_EN to make ADD/SUB saturate on
//   signed overflow. In the default build ADD/SUB wrap around.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   in_valid / in_ready     operand-side handshake (a, b, op)
//   out_valid / out_ready   result-side handshake (result, c, n, z, v)
//   a, b                    WIDTH-bit operands
//   op                      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                           101 NOT a, 110 SHL a, 111 SHR a (logical)
//   result, c, n, z, v      registered result and flags
// ---------------------------------------------------------------------------
module alu_pipe_n #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Stage 1 holding registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_c;
  logic             r_n;
  logic             r_z;
  logic             r_v;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // The output stage moves when it is empty or being drained; stage 1 moves
  // when it is empty or can hand over to stage 2.
  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // One extra bit keeps the carry out; SUB is a + ~b + 1 so c=1 means no borrow.
  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};

  // Opcode decode: raw result, carry and signed overflow of stage-1 operands.
  always_comb begin
    w_res_raw = {WIDTH{1'b0}};
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_res_raw = w_sum[WIDTH-1:0];
        w_c       = w_sum[WIDTH];
        w_v       = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res_raw = w_diff[WIDTH-1:0];
        w_c       = w_diff[WIDTH];
        w_v       = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_AND: w_res_raw = r_s1_a & r_s1_b;
      OP_OR:  w_res_raw = r_s1_a | r_s1_b;
      OP_XOR: w_res_raw = r_s1_a ^ r_s1_b;
      OP_NOT: w_res_raw = ~r_s1_a;
      OP_SHL: begin
        w_res_raw = {r_s1_a[WIDTH-2:0], 1'b0};
        w_c       = r_s1_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res_raw = {1'b0, r_s1_a[WIDTH-1:1]};
        w_c       = r_s1_a[0];
      end
      default: begin
        w_res_raw = {WIDTH{1'b0}};
        w_c       = 1'b0;
        w_v       = 1'b0;
      end
    endcase
  end

`ifdef ALU_PIPE_SAT_EN
  // Signed saturation: overflow only occurs on ADD/SUB, and the overflowed
  // direction always matches the sign of operand a.
  always_comb begin
    if (w_v) begin
      if (r_s1_a[WIDTH-1]) begin
        w_res = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_res = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      w_res = w_res_raw;
    end
  end
`else
  assign w_res = w_res_raw;
`endif

  // Stage 1: capture operands whenever the stage is free to advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= {WIDTH{1'b0}};
      r_s1_b     <= {WIDTH{1'b0}};
      r_s1_op    <= 3'b000;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= a;
        r_s1_b  <= b;
        r_s1_op <= op;
      end
    end
  end

  // Stage 2: register result and flags; held bit-stable while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_c         <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_v         <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_c      <= w_c;
        r_n      <= w_res[WIDTH-1];
        r_z      <= (w_res == {WIDTH{1'b0}});
        r_v      <= w_v;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign c         = r_c;
  assign n         = r_n;
  assign z         = r_z;
  assign v         = r_v;

endmodule

// File: tb/tb_alu_pipe_n.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe_n
//   Self-checking bench for alu_pipe_n (WIDTH=4). A queue holds the expected
//   {v,z,n,c,result} word of every accepted operation, computed with plain
//   integer arithmetic. Every delivered output is compared with the queue
//   head, and in_ready is compared with the pipeline occupancy each cycle.
//   Directed cases cover the fixed-value, latency, streaming, stall and
//   reset scenarios; a random phase mixes valid and backpressure.
// ---------------------------------------------------------------------------
module tb_alu_pipe_n;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         c;
  logic         n;
  logic         z;
  logic         v;

  alu_pipe_n #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c         (c),
    .n         (n),
    .z         (z),
    .v         (v)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // values seen in the most recent cycle
  logic        s_ov;
  logic        s_ir;
  logic        s_acc;
  logic [31:0] s_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference: {v,z,n,c,result} from the operation definitions.
  function automatic logic [31:0] ref_op(input int ai, input int bi, input int opi);
    int r, cf, vf, nf, zf, sa, sb, s;
    sa = (ai >= M/2) ? ai - M : ai;
    sb = (bi >= M/2) ? bi - M : bi;
    r = 0; cf = 0; vf = 0; s = 0;
    case (opi)
      0: begin
        s  = sa + sb;
        r  = (ai + bi) % M;
        cf = ((ai + bi) >= M) ? 1 : 0;
        vf = (s > M/2 - 1 || s < -M/2) ? 1 : 0;
`ifdef ALU_PIPE_SAT_EN
        if (vf == 1) r = (s > 0) ? M/2 - 1 : M/2;
`endif
      end
      1: begin
        s  = sa - sb;
        r  = (ai - bi + M) % M;
        cf = (ai >= bi) ? 1 : 0;
        vf = (s > M/2 - 1 || s < -M/2) ? 1 : 0;
`ifdef ALU_PIPE_SAT_EN
        if (vf == 1) r = (s > 0) ? M/2 - 1 : M/2;
`endif
      end
      2: r = ai & bi;
      3: r = ai | bi;
      4: r = ai ^ bi;
      5: r = M - 1 - ai;
      6: begin r = (ai * 2) % M; cf = (ai >= M/2) ? 1 : 0; end
      7: begin r = ai / 2;       cf = ai % 2;               end
      default: r = 0;
    endcase
    nf = (r >= M/2) ? 1 : 0;
    zf = (r == 0) ? 1 : 0;
    return 32'((vf << (W+3)) | (zf << (W+2)) | (nf << (W+1)) | (cf << W) | r);
  endfunction

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] iop, input logic ordy);
    int exp_ir;
    logic del;
    in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy;
    #1;
    exp_ir = (exp_q.size() == 2 && !ordy) ? 0 : 1;
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    s_ov   = out_valid;
    s_ir   = in_ready;
    s_acc  = iv && in_ready;
    s_word = 32'({v, z, n, c, result});
    del    = out_valid && ordy;
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
      else                   check("res_flags", s_word, exp_q[0]);
    end
    @(posedge clk);
    #1;
    if (del && exp_q.size() != 0) void'(exp_q.pop_front());
    if (s_acc) exp_q.push_back(ref_op(int'(ia), int'(ib), int'(iop)));
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, {W{1'b0}}, {W{1'b0}}, 3'd0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_ov", 32'(s_ov), 32'd0);
  endtask

  // Single operation into an empty pipe: checks 2-cycle latency and value.
  task automatic send_check(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [2:0] iop, input logic [31:0] expw);
    cycle(1'b1, ia, ib, iop, 1'b1);
    check({tag, "_acc"}, 32'(s_acc), 32'd1);
    idle(1'b1);
    check({tag, "_lat1"}, 32'(s_ov), 32'd0);
    idle(1'b1);
    check({tag, "_lat2"}, 32'(s_ov), 32'd1);
    check(tag, s_word, expw);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    #1;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_word", 32'({v, z, n, c, result}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    a = '0; b = '0; op = 3'd0;
    do_reset();

    // Fixed-value cases
`ifdef ALU_PIPE_SAT_EN
    send_check("add_ovf", 4'b0111, 4'b0001, 3'b000, 32'h87);
`else
    send_check("add_ovf", 4'b0111, 4'b0001, 3'b000, 32'hA8);
`endif
    send_check("sub_eq",  4'b0011, 4'b0011, 3'b001, 32'h50);
    send_check("sub_brw", 4'b0000, 4'b0001, 3'b001, 32'h2F);
    send_check("shl",     4'b1001, 4'b0000, 3'b110, 32'h12);
    send_check("shr",     4'b1001, 4'b0000, 3'b111, 32'h14);
    send_check("not",     4'b0000, 4'b0000, 3'b101, 32'h2F);
    drain();

    // Back-to-back stream of all opcodes at full throughput
    for (int i = 0; i < 10; i++) begin
      cycle(i < 8, W'($urandom()), W'($urandom()), 3'(i), 1'b1);
      if (i < 8)  check("stream_acc", 32'(s_acc), 32'd1);
      if (i >= 2) check("stream_ov", 32'(s_ov), 32'd1);
    end
    drain();

    // Backpressure for 5 cycles during a stream
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, W'($urandom()), W'($urandom()), 3'($urandom()), !(i >= 1 && i < 6));
      if (i >= 2 && i < 6) check("stall_in_ready", 32'(s_ir), 32'd0);
    end
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom()), W'($urandom()), W'($urandom()), 3'($urandom()),
            ($urandom_range(3) != 0));
    end
    drain();

    // Reset with both stages full
    cycle(1'b1, 4'd5, 4'd6, 3'b000, 1'b0);
    cycle(1'b1, 4'd3, 4'd4, 3'b011, 1'b0);
    idle(1'b0);
    check("full_ov", 32'(s_ov), 32'd1);
    check("full_in_ready", 32'(s_ir), 32'd0);
    do_reset();
    idle(1'b1);
    check("post_rst_ov1", 32'(s_ov), 32'd0);
    idle(1'b1);
    check("post_rst_ov2", 32'(s_ov), 32'd0);
    send_check("and_post_rst", 4'b1100, 4'b1010, 3'b010, 32'h28);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
